// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-stage load/store engine for the RV32I pipeline. Captures the decoded
// memory controls and effective address from M, performs the access on a
// word-addressed, byte-enabled req/ack data bus, holds the pipeline for wait
// states and returns sign/zero-extended load data.
//
// Configuration macro: MISALIGN_SPLIT_EN
//   defined   - misaligned accesses are split into two word beats.
//   undefined - misaligned accesses are rejected without bus activity and
//               flagged with misalign_err_M alongside done_M.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_M               valid load/store in M this cycle
//   MemWrite_M          1 = store, 0 = load
//   SizeSrc_M           00 word, 01 half, 10 byte, 11 word
//   LoadSign_M          1 = sign-extend load result
//   ALUResult_M         effective byte address
//   WriteData_M         right-aligned store data
//   Stall_M             hold F/D/E/M
//   done_M              one-cycle completion pulse
//   ReadData_M          extended load data, valid with done_M
//   misalign_err_M      one-cycle pulse for a rejected misaligned access
//   bus_req/we/addr/be/wdata  bus request side, stable until ack
//   bus_ack, bus_rdata  bus response side
//
// state | meaning
// IDLE  | waiting for req_M; capture the access when it arrives
// BEAT1 | first (or only) bus beat at the word containing the address
// BEAT2 | second beat of a split access, next word up
// DONE  | completion pulse; pipeline released

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_M,
    input  logic              MemWrite_M,
    input  logic [1:0]        SizeSrc_M,
    input  logic              LoadSign_M,
    input  logic [ADDR_W-1:0] ALUResult_M,
    input  logic [31:0]       WriteData_M,
    output logic              Stall_M,
    output logic              done_M,
    output logic [31:0]       ReadData_M,
    output logic              misalign_err_M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [31:0]       rdata_q;

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            2'b01:   lane_mask = 4'b0011;
            2'b10:   lane_mask = 4'b0001;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   is_misaligned = (off == 2'd3);
            2'b10:   is_misaligned = 1'b0;
            default: is_misaligned = (off != 2'd0);
        endcase
    endfunction

    // pair = {hi word, lo word}; the addressed bytes start at byte 'off'.
    function automatic logic [31:0] extend_load(input logic [63:0] pair,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        sign);
        logic [31:0] s;
        s = 32'(pair >> {off, 3'b000});
        case (size)
            2'b01:   extend_load = {{16{sign & s[15]}}, s[15:0]};
            2'b10:   extend_load = {{24{sign & s[7]}}, s[7:0]};
            default: extend_load = s;
        endcase
    endfunction

    logic [1:0]        off;
    logic              mis_q;
    logic [ADDR_W-1:0] word_addr;
    logic [63:0]       wd64;
    logic [7:0]        be8;

    assign off       = addr_q[1:0];
    assign mis_q     = is_misaligned(size_q, off);
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    // Lane-positioned store data and enables across two consecutive words.
    assign wd64      = {32'b0, wdata_q} << {off, 3'b000};
    assign be8       = {4'b0, lane_mask(size_q)} << off;

`ifndef MISALIGN_SPLIT_EN
    logic idle_mis;
    logic err_q;
    assign idle_mis = is_misaligned(SizeSrc_M, ALUResult_M[1:0]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Stall_M    = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_be     = 4'b0;
        bus_wdata  = 32'b0;
        case (state)
            IDLE: begin
                if (req_M) begin
                    Stall_M = 1'b1;
`ifdef MISALIGN_SPLIT_EN
                    state_next = BEAT1;
`else
                    state_next = idle_mis ? DONE : BEAT1;
`endif
                end
            end
            BEAT1: begin
                Stall_M   = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = word_addr;
                bus_be    = be8[3:0];
                bus_wdata = wd64[31:0];
                // Without splitting, a misaligned access never reaches BEAT1.
                if (bus_ack) state_next = mis_q ? BEAT2 : DONE;
            end
            BEAT2: begin
                Stall_M   = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = word_addr + ADDR_W'(4);
                bus_be    = be8[7:4];
                bus_wdata = wd64[63:32];
                if (bus_ack) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= 2'b0;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 32'b0;
            lo_q    <= 32'b0;
            rdata_q <= 32'b0;
        end else begin
            // Result register only holds data during the DONE cycle.
            rdata_q <= 32'b0;
            case (state)
                IDLE: begin
                    if (req_M) begin
                        addr_q  <= ALUResult_M;
                        size_q  <= SizeSrc_M;
                        sign_q  <= LoadSign_M;
                        we_q    <= MemWrite_M;
                        wdata_q <= WriteData_M;
                    end
                end
                BEAT1: begin
                    if (bus_ack) begin
                        lo_q <= bus_rdata;
                        if (!mis_q && !we_q)
                            rdata_q <= extend_load({32'b0, bus_rdata}, off, size_q, sign_q);
                    end
                end
                BEAT2: begin
                    if (bus_ack && !we_q)
                        rdata_q <= extend_load({bus_rdata, lo_q}, off, size_q, sign_q);
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_SPLIT_EN
    assign misalign_err_M = 1'b0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && req_M && idle_mis;
        end
    end
    assign misalign_err_M = err_q;
`endif

    assign done_M     = (state == DONE);
    assign ReadData_M = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_M;
    logic        MemWrite_M;
    logic [1:0]  SizeSrc_M;
    logic        LoadSign_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic        Stall_M;
    logic        done_M;
    logic [31:0] ReadData_M;
    logic        misalign_err_M;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int tests = 0;
    int fails = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_M(req_M), .MemWrite_M(MemWrite_M),
        .SizeSrc_M(SizeSrc_M), .LoadSign_M(LoadSign_M), .ALUResult_M(ALUResult_M),
        .WriteData_M(WriteData_M), .Stall_M(Stall_M), .done_M(done_M),
        .ReadData_M(ReadData_M), .misalign_err_M(misalign_err_M),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rlo;
        logic [31:0] rhi;
        int          waits;
        logic        mis;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] a2;
        logic [3:0]  be2;
        logic [31:0] wd2;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (vec %0d): got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nb;
        logic exp_err;
        logic [31:0] exp_rd;
`ifdef MISALIGN_SPLIT_EN
        nb = v.mis ? 2 : 1;
        exp_err = 1'b0;
        exp_rd = v.rd;
`else
        nb = v.mis ? 0 : 1;
        exp_err = v.mis;
        exp_rd = v.mis ? 32'h0 : v.rd;
`endif
        @(negedge clk);
        req_M = 1'b1; MemWrite_M = v.we; SizeSrc_M = v.size; LoadSign_M = v.sign;
        ALUResult_M = v.addr; WriteData_M = v.wdata;
        #1 check("stall_accept", idx, 32'(Stall_M), 32'h1);
        @(posedge clk); #1;
        req_M = 1'b0; ALUResult_M = 32'h0; WriteData_M = 32'h0;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w <= v.waits; w++) begin
                check("bus_req", idx, 32'(bus_req), 32'h1);
                check("bus_addr", idx, bus_addr, (b == 0) ? v.a1 : v.a2);
                check("bus_be", idx, 32'(bus_be), 32'((b == 0) ? v.be1 : v.be2));
                check("bus_we", idx, 32'(bus_we), 32'(v.we));
                if (v.we) check("bus_wdata", idx, bus_wdata, (b == 0) ? v.wd1 : v.wd2);
                check("stall_beat", idx, 32'(Stall_M), 32'h1);
                check("done_early", idx, 32'(done_M), 32'h0);
                if (w == v.waits) begin
                    bus_ack = 1'b1;
                    bus_rdata = (b == 0) ? v.rlo : v.rhi;
                end
                @(posedge clk); #1;
                bus_ack = 1'b0;
                bus_rdata = 32'hA5A5_5A5A;
            end
        end
        check("done", idx, 32'(done_M), 32'h1);
        check("misalign_err", idx, 32'(misalign_err_M), 32'(exp_err));
        if (!v.we || exp_err) check("read_data", idx, ReadData_M, exp_rd);
        check("stall_done", idx, 32'(Stall_M), 32'h0);
        check("bus_req_done", idx, 32'(bus_req), 32'h0);
        @(posedge clk); #1;
        check("done_pulse", idx, 32'(done_M), 32'h0);
        check("err_pulse", idx, 32'(misalign_err_M), 32'h0);
    endtask

    initial begin
        //            we size  sg addr           wdata          rlo            rhi          wt mis a1             be1   wd1            a2             be2   wd2            rd
        vecs.push_back('{0, 2'b00, 0, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 32'h0,        2, 0, 32'h0000_0100, 4'hF, 32'h0,         32'h0,         4'h0, 32'h0,         32'hDEADBEEF});
        vecs.push_back('{0, 2'b10, 1, 32'h0000_0103, 32'h0,         32'h80FFFFFF, 32'h0,        0, 0, 32'h0000_0100, 4'h8, 32'h0,         32'h0,         4'h0, 32'h0,         32'hFFFFFF80});
        vecs.push_back('{0, 2'b10, 0, 32'h0000_0103, 32'h0,         32'h80FFFFFF, 32'h0,        0, 0, 32'h0000_0100, 4'h8, 32'h0,         32'h0,         4'h0, 32'h0,         32'h00000080});
        vecs.push_back('{1, 2'b01, 0, 32'h0000_0102, 32'h0000ABCD,  32'h0,        32'h0,        1, 0, 32'h0000_0100, 4'hC, 32'hABCD0000,  32'h0,         4'h0, 32'h0,         32'h0});
        vecs.push_back('{1, 2'b00, 0, 32'h0000_0101, 32'h11223344,  32'h0,        32'h0,        0, 1, 32'h0000_0100, 4'hE, 32'h22334400,  32'h0000_0104, 4'h1, 32'h00000011,  32'h0});
        vecs.push_back('{0, 2'b01, 1, 32'h0000_01FF, 32'h0,         32'hAB000000, 32'h000000FF, 1, 1, 32'h0000_01FC, 4'h8, 32'h0,         32'h0000_0200, 4'h1, 32'h0,         32'hFFFFFFAB});
        vecs.push_back('{0, 2'b01, 0, 32'h0000_0102, 32'h0,         32'h87654321, 32'h0,        1, 0, 32'h0000_0100, 4'hC, 32'h0,         32'h0,         4'h0, 32'h0,         32'h00008765});
        vecs.push_back('{0, 2'b01, 1, 32'h0000_0102, 32'h0,         32'h87654321, 32'h0,        0, 0, 32'h0000_0100, 4'hC, 32'h0,         32'h0,         4'h0, 32'h0,         32'hFFFF8765});
        vecs.push_back('{1, 2'b10, 0, 32'h0000_0101, 32'h000000A5,  32'h0,        32'h0,        0, 0, 32'h0000_0100, 4'h2, 32'h0000A500,  32'h0,         4'h0, 32'h0,         32'h0});
        vecs.push_back('{1, 2'b11, 0, 32'h0000_0200, 32'hCAFEF00D,  32'h0,        32'h0,        0, 0, 32'h0000_0200, 4'hF, 32'hCAFEF00D,  32'h0,         4'h0, 32'h0,         32'h0});
        vecs.push_back('{0, 2'b10, 0, 32'h0000_0000, 32'h0,         32'h12345678, 32'h0,        0, 0, 32'h0000_0000, 4'h1, 32'h0,         32'h0,         4'h0, 32'h0,         32'h00000078});
        vecs.push_back('{0, 2'b10, 1, 32'h0000_0102, 32'h0,         32'h00F00000, 32'h0,        0, 0, 32'h0000_0100, 4'h4, 32'h0,         32'h0,         4'h0, 32'h0,         32'hFFFFFFF0});
        vecs.push_back('{0, 2'b01, 1, 32'h0000_0101, 32'h0,         32'h00ABCD00, 32'h0,        0, 0, 32'h0000_0100, 4'h6, 32'h0,         32'h0,         4'h0, 32'h0,         32'hFFFFABCD});
        vecs.push_back('{0, 2'b00, 0, 32'hFFFF_FFFE, 32'h0,         32'hBBAA0000, 32'h0000DDCC, 0, 1, 32'hFFFF_FFFC, 4'hC, 32'h0,         32'h0000_0000, 4'h3, 32'h0,         32'hDDCCBBAA});
        vecs.push_back('{0, 2'b01, 0, 32'h0000_0103, 32'h0,         32'h5A000000, 32'h000000C3, 2, 1, 32'h0000_0100, 4'h8, 32'h0,         32'h0000_0104, 4'h1, 32'h0,         32'h0000C35A});

        rst_n = 1'b0; req_M = 1'b0; MemWrite_M = 1'b0; SizeSrc_M = 2'b00; LoadSign_M = 1'b0;
        ALUResult_M = 32'h0; WriteData_M = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        #22;
        check("rst_stall", -1, 32'(Stall_M), 32'h0);
        check("rst_done", -1, 32'(done_M), 32'h0);
        check("rst_rdata", -1, ReadData_M, 32'h0);
        check("rst_err", -1, 32'(misalign_err_M), 32'h0);
        check("rst_bus_req", -1, 32'(bus_req), 32'h0);
        check("rst_bus_we", -1, 32'(bus_we), 32'h0);
        check("rst_bus_addr", -1, bus_addr, 32'h0);
        check("rst_bus_be", -1, 32'(bus_be), 32'h0);
        check("rst_bus_wdata", -1, bus_wdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Stray ack with no request outstanding must do nothing.
        @(negedge clk); bus_ack = 1'b1;
        @(posedge clk); #1;
        check("stray_ack_done", -1, 32'(done_M), 32'h0);
        check("stray_ack_req", -1, 32'(bus_req), 32'h0);
        bus_ack = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset during a BEAT1 wait state abandons the access.
        @(negedge clk);
        req_M = 1'b1; MemWrite_M = 1'b0; SizeSrc_M = 2'b00; ALUResult_M = 32'h100;
        @(posedge clk); #1;
        req_M = 1'b0;
        check("rst_mid_req_before", -2, 32'(bus_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", -2, 32'(bus_req), 32'h0);
        check("rst_mid_stall", -2, 32'(Stall_M), 32'h0);
        check("rst_mid_addr", -2, bus_addr, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_no_done", -2, 32'(done_M), 32'h0);
        check("rst_mid_no_retry", -2, 32'(bus_req), 32'h0);
        run_vec(0, vecs[0]);

        // req_M seen during DONE belongs to the completing instruction.
        @(negedge clk);
        req_M = 1'b1; MemWrite_M = 1'b0; SizeSrc_M = 2'b00; LoadSign_M = 1'b0; ALUResult_M = 32'h300;
        @(posedge clk); #1;
        req_M = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h0000_0055;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check("done_seq_done", -3, 32'(done_M), 32'h1);
        check("done_seq_rd", -3, ReadData_M, 32'h0000_0055);
        req_M = 1'b1; ALUResult_M = 32'h400;
        #1 check("done_seq_stall", -3, 32'(Stall_M), 32'h0);
        @(posedge clk); #1;
        check("idle_not_accepted", -3, 32'(bus_req), 32'h0);
        check("idle_stall", -3, 32'(Stall_M), 32'h1);
        check("idle_done", -3, 32'(done_M), 32'h0);
        @(posedge clk); #1;
        req_M = 1'b0;
        check("next_req", -3, 32'(bus_req), 32'h1);
        check("next_addr", -3, bus_addr, 32'h400);
        bus_ack = 1'b1; bus_rdata = 32'h0000_0077;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check("next_done", -3, 32'(done_M), 32'h1);
        check("next_rd", -3, ReadData_M, 32'h0000_0077);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
